// File: rtl/orient_hist32_pkg.sv
// orient_hist32_pkg: shared bin geometry, state encoding and saturating add
package orient_hist32_pkg;
  localparam int NBINS = 32;
  localparam int BIN_W = 5;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_SCAN = 2'd2, S_DONE = 2'd3} state_e;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int acc_w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << acc_w) - 33'd1;
    return s > m ? m[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/orient_hist32_if.sv
// orient_hist32_if: sample stream in, dominant-bin result out
interface orient_hist32_if #(parameter int MAG_W = 8, parameter int ACC_W = 16);
  import orient_hist32_pkg::*;
  logic start, in_valid, in_last, in_ready, out_valid, out_ready, busy;
  logic [BIN_W-1:0] in_bin, out_bin;
  logic [MAG_W-1:0] in_mag;
  logic [ACC_W-1:0] out_peak;
  modport master(output start, in_valid, in_bin, in_mag, in_last, out_ready,
                 input in_ready, out_valid, out_bin, out_peak, busy);
  modport slave(input start, in_valid, in_bin, in_mag, in_last, out_ready,
                output in_ready, out_valid, out_bin, out_peak, busy);
endinterface

// File: rtl/orient_hist32_hist_peak_scan.sv
// orient_hist32_hist_peak_scan: 32-cycle running-max search, ties keep lowest index
module orient_hist32_hist_peak_scan import orient_hist32_pkg::*; #(parameter int ACC_W = 16) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [ACC_W-1:0] val_i,
  output logic [BIN_W-1:0] idx_o,
  output logic             done_o,
  output logic [BIN_W-1:0] bin_o,
  output logic [ACC_W-1:0] max_o
);
  logic run_q, run_d, gt;
  logic [BIN_W-1:0] idx_q, idx_d, bin_q, bin_d;
  logic [ACC_W-1:0] max_q, max_d;
  // step the index and replace the max only on a strictly greater value
  always_comb begin
    done_o = run_q && idx_q == BIN_W'(NBINS - 1);
    gt = run_q && val_i > max_q;
    run_d = start_i ? 1'b1 : run_q && !done_o;
    idx_d = start_i ? '0 : run_q ? idx_q + 1'b1 : idx_q;
    max_d = start_i ? '0 : gt ? val_i : max_q;
    bin_d = start_i ? '0 : gt ? idx_q : bin_q;
  end
  // scan registers
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      idx_q <= '0;
      max_q <= '0;
      bin_q <= '0;
    end else begin
      run_q <= run_d;
      idx_q <= idx_d;
      max_q <= max_d;
      bin_q <= bin_d;
    end
  end
  assign idx_o = idx_q;
  assign bin_o = bin_q;
  assign max_o = max_q;
endmodule

// File: rtl/orient_hist32.sv
// orient_hist32: 32-bin orientation histogram with dominant-bin readout
module orient_hist32 import orient_hist32_pkg::*; #(parameter int MAG_W = 8, parameter int ACC_W = 16) (
  input logic clk,
  input logic rst,
  orient_hist32_if.slave bus_io
);
  state_e state_q, state_d;
  logic [ACC_W-1:0] hist_q [NBINS];
  logic [ACC_W-1:0] hist_d [NBINS];
  logic accept, last_acc, clear, scan_done;
  logic [BIN_W-1:0] scan_idx;
  // window sequencing and handshake outputs
  always_comb begin
    clear = state_q == S_IDLE && bus_io.start;
    accept = state_q == S_ACCUM && bus_io.in_valid;
    last_acc = accept && bus_io.in_last;
    state_d = clear ? S_ACCUM :
              last_acc ? S_SCAN :
              (state_q == S_SCAN && scan_done) ? S_DONE :
              (state_q == S_DONE && bus_io.out_ready) ? S_IDLE : state_q;
    bus_io.in_ready = state_q == S_ACCUM;
    bus_io.out_valid = state_q == S_DONE;
    bus_io.busy = state_q != S_IDLE;
  end
  // single-cycle read-modify-write so back-to-back hits on one bin never lose an update
  always_comb begin
    hist_d = hist_q;
    if (clear) hist_d = '{default: '0};
    else if (accept) hist_d[bus_io.in_bin] = ACC_W'(sat_add(32'(hist_q[bus_io.in_bin]), 32'(bus_io.in_mag[MAG_W-1:0]), ACC_W));
  end
  // state and histogram registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hist_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      hist_q <= hist_d;
    end
  end
  orient_hist32_hist_peak_scan #(.ACC_W(ACC_W)) u_scan (
    .clk(clk),
    .rst(rst),
    .start_i(last_acc),
    .val_i(hist_q[scan_idx]),
    .idx_o(scan_idx),
    .done_o(scan_done),
    .bin_o(bus_io.out_bin),
    .max_o(bus_io.out_peak)
  );
endmodule

// File: tb/tb_orient_hist32.sv
// tb_orient_hist32: directed and random windows against an array histogram model
module tb_orient_hist32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int unsigned hist_m [32];
  orient_hist32_if #(.MAG_W(8), .ACC_W(16)) bus();
  orient_hist32 #(.MAG_W(8), .ACC_W(16)) dut(.clk(clk), .rst(rst), .bus_io(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_win;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    foreach (hist_m[i]) hist_m[i] = 0;
  endtask

  task automatic send(input int b, input int m, input bit last);
    bus.in_valid = 1'b1;
    bus.in_bin = 5'(b);
    bus.in_mag = 8'(m);
    bus.in_last = last;
    tick;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    hist_m[b] = (hist_m[b] + m > 65535) ? 65535 : hist_m[b] + m;
  endtask

  task automatic finish_win(input string tag, input int hold);
    int n = 0;
    int unsigned ep = 0;
    int eb = -1;
    logic [31:0] b0, p0;
    foreach (hist_m[i]) if (hist_m[i] > ep) ep = hist_m[i];
    foreach (hist_m[i]) if (eb < 0 && hist_m[i] == ep) eb = i;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    check({tag, "_latency"}, n, 32);
    check({tag, "_bin"}, bus.out_bin, eb);
    check({tag, "_peak"}, bus.out_peak, ep);
    if (hold > 0) begin
      b0 = bus.out_bin;
      p0 = bus.out_peak;
      repeat (hold) tick;
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_busy"}, bus.busy, 1);
      check({tag, "_hold_bin"}, bus.out_bin, b0);
      check({tag, "_hold_peak"}, bus.out_peak, p0);
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, bus.out_valid, 0);
    check({tag, "_idle_busy"}, bus.busy, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bin = '0;
    bus.in_mag = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_bin", bus.out_bin, 0);
    check("rst_out_peak", bus.out_peak, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    tick;
    check("idle_busy", bus.busy, 0);
    start_win;
    check("accum_ready", bus.in_ready, 1);
    check("accum_busy", bus.busy, 1);
    send(7, 200, 1);
    check("scan_ready", bus.in_ready, 0);
    finish_win("single", 0);
    start_win;
    repeat (9) send(3, 100, 0);
    send(3, 100, 1);
    finish_win("stream", 0);
    start_win;
    send(20, 50, 0);
    send(5, 50, 0);
    send(31, 50, 1);
    finish_win("tie", 0);
    start_win;
    repeat (299) send(31, 255, 0);
    send(31, 255, 1);
    finish_win("sat", 0);
    start_win;
    send(12, 77, 0);
    send(9, 90, 1);
    finish_win("backpressure", 20);
    start_win;
    send(0, 1, 1);
    finish_win("restart", 0);
    start_win;
    send(4, 10, 0);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check("start_ignored_ready", bus.in_ready, 1);
    send(4, 5, 1);
    finish_win("start_ignored", 0);
    start_win;
    repeat (5) send(1, 200, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_bin", bus.out_bin, 0);
    check("midrst_out_peak", bus.out_peak, 0);
    check("midrst_busy", bus.busy, 0);
    tick;
    start_win;
    send(2, 3, 0);
    send(9, 3, 1);
    finish_win("post_rst", 0);
    start_win;
    repeat (3) send($urandom_range(0, 31), 0, 0);
    send($urandom_range(0, 31), 0, 1);
    finish_win("all_zero", 0);
    for (int w = 0; w < 8; w++) begin
      int len = $urandom_range(1, 40);
      int hi = (w % 2 == 0) ? 31 : 3;
      start_win;
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) tick;
        send($urandom_range(0, hi), $urandom_range(0, 255), k == len - 1);
      end
      finish_win($sformatf("rand%0d", w), $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
